cla_word_sequencer: RTL and testbench
=====================================

# cla_word_sequencer

Multi-cycle wide-operand adder/subtractor controller. It shares one narrow `carry_lookahead_adder` instance across the chunks of a `WIDTH*WORDS`-bit operand pair and processes one chunk per cycle, LS chunk first. A flop carries the carry between chunks. It sits between a requester that issues wide add/sub operations and the narrow carry-lookahead datapath. A start/result handshake sequences the work.

## Interface
- `WIDTH`, default 32: chunk width; the adder instance is `WIDTH+1` bits wide.
- `WORDS`, default 4: number of chunks, minimum 2. Total operand width `N = WIDTH*WORDS`.
- `i_clk`, input, 1: clock. Everything is rising-edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_start_valid`, input, 1: operation request.
- `o_start_ready`, output, 1: request is accepted this cycle when high together with `i_start_valid`.
- `i_sub`, input, 1: 0 selects `A+B`, 1 selects `A-B`. Captured at accept.
- `i_add1`, input, N: operand A. Captured at accept.
- `i_add2`, input, N: operand B. Captured at accept.
- `o_busy`, output, 1: high in RUN.
- `o_valid`, output, 1: result available.
- `i_ready`, input, 1: consumer takes the result.
- `o_result`, output, N+1: `{carry_out, sum}`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values:
  - `o_valid=0`, `o_busy=0`, `o_result=0`.
  - `o_start_ready=1`, because it is decoded from the IDLE state.
  - Chunk index = 0, carry flop = 0, operand registers = 0.
- IDLE:
  - `o_start_ready=1`.
  - On `i_start_valid`, capture A, `i_sub`, and B. If `i_sub` is set, capture B bitwise inverted.
  - Load the carry flop with `i_sub`, clear the index, and go to RUN.
  - Clear `o_result` at accept.
- RUN, chunk k = index:
  - Adder operands: `{A[k], 1'b1}` and `{B'[k], carry}`, each `WIDTH+1` bits.
  - Adder result bits `[WIDTH+1:1]` equal `A[k] + B'[k] + carry`. Bit 0 is discarded.
  - Each cycle, write result bits `[WIDTH:1]` into `o_result` chunk k.
  - Each cycle, load the carry flop from adder bit `WIDTH+1`.
  - Increment the index.
  - When k = WORDS-1, also write the carry into `o_result[N]` and go to DONE.
- DONE:
  - `o_valid=1`; `o_result` is held stable.
  - When `i_ready` is high, go to IDLE and drop `o_valid` on that edge.
  - `i_start_valid` is ignored in DONE.
- Arithmetic is modulo 2^N:
  - For subtraction, `o_result[N]=1` means no borrow (A ≥ B unsigned).
  - Signed overflow is not reported.
- `i_start_valid` is ignored outside IDLE. No abort exists other than `i_rst`.
- Reset during RUN or DONE: all state and outputs return to reset values immediately (asynchronous). Partial results are discarded and no `o_valid` pulse is produced.

## Timing
- Accept edge = E0.
- Chunk k is computed in the cycle after edge E(k) and registered at E(k+1).
- `o_valid` is high from E(WORDS) until the edge at which `i_ready` is seen high.
- `i_ready` held high: DONE lasts one cycle and IDLE is re-entered at E(WORDS+1). The next accept is possible at E(WORDS+2), so peak throughput is one operation per `WORDS+2` cycles.
- `o_result` chunks update one per cycle during RUN. Only the value while `o_valid=1` is defined for the consumer.
- The adder path is combinational within one cycle. There are no multicycle paths.

## Structure
- Shared package `cla_seq_pkg` holds:
  - the state encoding localparams `ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_DONE=2'd2`;
  - the index-width function (`$clog2(WORDS)`).
- Single sub-module: the existing `carry_lookahead_adder`, instantiated with `WIDTH+1`.
- Chunk select is an indexed part-select on the operand registers. There is no per-chunk adder replication.

## Test plan
All scenarios use WIDTH=8, WORDS=4.
- `i_add1=32'h000000FF`, `i_add2=32'h00000001`, add → `o_result=33'h0_00000100`. `o_valid` rises exactly 4 edges after accept; `o_busy` is high for 4 cycles.
- `i_add1=32'hFFFFFFFF`, `i_add2=32'h00000001`, add → `o_result=33'h1_00000000`; the carry ripples through all chunks.
- `i_add1=32'h00000005`, `i_add2=32'h00000007`, sub → `o_result=33'h0_FFFFFFFE`. Then `7-5` → `33'h1_00000002`.
- Backpressure: `i_ready=0` for 10 cycles in DONE → `o_valid` stays 1, `o_result` is stable, `o_start_ready=0`, and a pulse on `i_start_valid` is not accepted.
- Assert `i_rst` asynchronously mid-edge-cycle while chunk 2 is in RUN → all outputs take reset values before the next edge. After release, `12345678h+11111111h` → `33'h0_23456789`.
- Back-to-back with `i_start_valid` and `i_ready` held high → accepts spaced exactly 6 cycles apart, each result correct against a reference model, over 1000 random operations including `i_sub` mixing.

Source files
------------

// File: rtl/cla_word_sequencer_pkg.sv
// Shared definitions for the chunked carry-lookahead word sequencer.
package cla_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Width of the chunk index; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_word_sequencer_cla.sv
// Narrow carry-lookahead adder shared by the word sequencer.
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             c_acc;

    assign gen  = i_a & i_b;
    assign prop = i_a ^ i_b;

    // Each carry is expanded independently from generate/propagate terms so it flattens to its own lookahead equation.
    always_comb begin
        carry = '0;
        c_acc = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            c_acc = i_cin;
            for (int j = 0; j < i; j++) begin
                c_acc = gen[j] | (prop[j] & c_acc);
            end
            carry[i] = c_acc;
        end
    end

    assign o_sum  = prop ^ carry[WIDTH-1:0];
    assign o_cout = carry[WIDTH];

endmodule

// File: rtl/cla_word_sequencer.sv
// Multi-cycle wide add/sub: one narrow adder walks the operand chunks LS-first, carrying between chunks in a flop.
module cla_word_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start_valid,
    output logic                     o_start_ready,
    input  logic                     i_sub,
    input  logic [WIDTH*WORDS-1:0]   i_add1,
    input  logic [WIDTH*WORDS-1:0]   i_add2,
    output logic                     o_busy,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH*WORDS:0]     o_result
);

    localparam int N  = WIDTH * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N:0]      result_q, result_d;

    logic [WIDTH:0]  add_a;
    logic [WIDTH:0]  add_b;
    logic [WIDTH:0]  add_sum;
    logic            add_cout;
    logic            unused_sum_lsb;

    // The forced 1 in bit 0 of A plus the carry flop in bit 0 of B injects the inter-chunk carry into bit 1.
    assign add_a = {a_q[idx_q*WIDTH +: WIDTH], 1'b1};
    assign add_b = {b_q[idx_q*WIDTH +: WIDTH], carry_q};
    assign unused_sum_lsb = add_sum[0];

    carry_lookahead_adder #(
        .WIDTH (WIDTH + 1)
    ) u_cla (
        .i_a    (add_a),
        .i_b    (add_b),
        .i_cin  (1'b0),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // Next-state and datapath updates: capture at accept, one chunk per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (i_start_valid) begin
                    a_d      = i_add1;
                    b_d      = i_sub ? ~i_add2 : i_add2;
                    carry_d  = i_sub;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q*WIDTH +: WIDTH] = add_sum[WIDTH:1];
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d[N] = add_cout;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign o_start_ready = (state_q == S_IDLE);
    assign o_busy        = (state_q == S_RUN);
    assign o_valid       = (state_q == S_DONE);
    assign o_result      = result_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer at WIDTH=8, WORDS=4.
module tb_cla_word_sequencer;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic           clk;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic           sub;
    logic [N-1:0]   add1;
    logic [N-1:0]   add2;
    logic           busy;
    logic           valid;
    logic           ready;
    logic [N:0]     result;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs[10];

    cla_word_sequencer #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_sub         (sub),
        .i_add1        (add1),
        .i_add2        (add2),
        .o_busy        (busy),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic; for subtraction the top bit means "no borrow".
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) begin
            return {(a >= b), a - b};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one request at a negedge and release it just after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        check_output("start_ready before accept", 64'(start_ready), 64'd1);
        add1 = a;
        add2 = b;
        sub  = s;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int edges;
        int busy_cycles;
        edges = 0;
        busy_cycles = 0;
        ready = 1'b1;
        apply_stimulus(v.a, v.b, v.s);
        while (edges < 20) begin
            @(negedge clk);
            if (valid) break;
            if (busy) busy_cycles++;
            edges++;
        end
        check_output($sformatf("vec%0d valid latency", idx), 64'(edges), 64'(WORDS));
        check_output($sformatf("vec%0d busy cycles", idx), 64'(busy_cycles), 64'(WORDS));
        check_output($sformatf("vec%0d result", idx), 64'(result), 64'(v.exp));
        @(negedge clk);
        check_output($sformatf("vec%0d valid drop", idx), 64'(valid), 64'd0);
        check_output($sformatf("vec%0d back to idle", idx), 64'(start_ready), 64'd1);
    endtask

    initial begin
        logic [32:0] exp_q[$];
        logic [32:0] exp_v;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int edges;
        int issued;
        int done;
        int last;
        int cyc;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 33'h0_00000100};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 33'h0_FFFFFFFE};
        vecs[3] = '{32'h00000007, 32'h00000005, 1'b1, 33'h1_00000002};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000};
        vecs[6] = '{32'h1234ABCD, 32'h1234ABCD, 1'b1, 33'h1_00000000};
        vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 33'h0_FFFFFFFF};
        vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_FFFFFFFE};
        vecs[9] = '{32'h00FF00FF, 32'h00010001, 1'b0, 33'h0_01000100};

        rst = 1'b0;
        start_valid = 1'b0;
        sub = 1'b0;
        add1 = '0;
        add2 = '0;
        ready = 1'b1;

        #1 rst = 1'b1;
        #2;
        check_output("reset start_ready", 64'(start_ready), 64'd1);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset valid", 64'(valid), 64'd0);
        check_output("reset result", 64'(result), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vector(vecs[i], i);
        end

        // Backpressure: result must hold in DONE and a new request must be ignored.
        ready = 1'b0;
        apply_stimulus(32'hDEADBEEF, 32'h11111111, 1'b0);
        edges = 0;
        while (edges < 20) begin
            @(negedge clk);
            if (valid) break;
            edges++;
        end
        check_output("bp valid latency", 64'(edges), 64'(WORDS));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp valid held", 64'(valid), 64'd1);
            check_output("bp result held", 64'(result), 64'h0_EFBED000);
            check_output("bp start_ready low", 64'(start_ready), 64'd0);
            if (i == 3) begin
                add1 = 32'h0000_0001;
                add2 = 32'h0000_0002;
                sub = 1'b0;
                start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
        end
        ready = 1'b1;
        @(negedge clk);
        check_output("bp valid drop", 64'(valid), 64'd0);
        check_output("bp no hidden accept", 64'(busy), 64'd0);
        check_output("bp idle again", 64'(start_ready), 64'd1);

        // Asynchronous reset while chunk 2 is being computed.
        apply_stimulus(32'hAAAA5555, 32'h12344321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("pre-reset busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_output("async reset busy", 64'(busy), 64'd0);
        check_output("async reset valid", 64'(valid), 64'd0);
        check_output("async reset result", 64'(result), 64'd0);
        check_output("async reset start_ready", 64'(start_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vector('{32'h12345678, 32'h11111111, 1'b0, 33'h0_23456789}, 10);

        // Back-to-back random operations with start and ready held high.
        issued = 0;
        done = 0;
        last = -1;
        cyc = 0;
        ready = 1'b1;
        while (done < 1000 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check_output("random unexpected result", 64'(result), 64'h1_FFFF_FFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_output($sformatf("random result %0d", done), 64'(result), 64'(exp_v));
                end
                done++;
            end
            if (start_ready) begin
                if (issued < 1000) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                    rs = 1'($urandom_range(0, 1));
                    add1 = ra;
                    add2 = rb;
                    sub = rs;
                    start_valid = 1'b1;
                    exp_q.push_back(model(ra, rb, rs));
                    if (last >= 0) begin
                        check_output("accept spacing", 64'(cyc - last), 64'(WORDS + 2));
                    end
                    last = cyc;
                    issued++;
                end else begin
                    start_valid = 1'b0;
                end
            end
        end
        start_valid = 1'b0;
        check_output("random ops completed", 64'(done), 64'd1000);
        check_output("random queue drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
